// File: rtl/router_fsm_if.sv
// Control/status bundle between the router control FSM and its neighbours
// (router_sync, register block, packet source).
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic [2:0] state;

    // Level signals sampled on the rising clock edge; there is no valid/ready
    // pair here, so every input is taken as-is at each edge and every output is
    // a registered-state decode that is stable for the whole cycle.
    modport master (
        input  pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, state
    );

    modport slave (
        output pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, state
    );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: walks each packet through header,
// payload and parity phases into the addressed output FIFO.
module router_fsm #(
    parameter logic [1:0] ADDR_INVALID = 2'b11,
    parameter int         STATE_W      = 3
) (
    input  logic         clock,
    input  logic         resetn,
    router_fsm_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] addr_q;
    logic       empty_in;
    logic       empty_addr;
    logic       soft_addr;

    always_comb begin
        empty_in = 1'b0;
        case (bus.data_in)
            2'd0:    empty_in = bus.fifo_empty_0;
            2'd1:    empty_in = bus.fifo_empty_1;
            2'd2:    empty_in = bus.fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
    end

    // Address 3 has no FIFO behind it, so it never reports empty or soft reset.
    always_comb begin
        empty_addr = 1'b0;
        soft_addr  = 1'b0;
        case (addr_q)
            2'd0: begin empty_addr = bus.fifo_empty_0; soft_addr = bus.soft_reset_0; end
            2'd1: begin empty_addr = bus.fifo_empty_1; soft_addr = bus.soft_reset_1; end
            2'd2: begin empty_addr = bus.fifo_empty_2; soft_addr = bus.soft_reset_2; end
            default: begin empty_addr = 1'b0; soft_addr = 1'b0; end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS) addr_q <= bus.data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && (bus.data_in != ADDR_INVALID))
                    state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: if (empty_addr) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
        endcase
        // A soft reset of the addressed FIFO abandons the packet from any phase.
        if ((state_q != DECODE_ADDRESS) && soft_addr) state_d = DECODE_ADDRESS;
    end

    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.busy          = 1'b0;
        case (state_q)
            DECODE_ADDRESS:  bus.detect_add = 1'b1;
            WAIT_TILL_EMPTY: bus.busy = 1'b1;
            LOAD_FIRST_DATA: begin
                bus.busy          = 1'b1;
                bus.lfd_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                bus.busy       = 1'b1;
                bus.full_state = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                bus.busy          = 1'b1;
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                bus.busy          = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                bus.busy        = 1'b1;
                bus.rst_int_reg = 1'b1;
            end
            default: bus.detect_add = 1'b1;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios plus a randomized run
// against a phase-level model of the router control sequence.
module tb_router_fsm;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    router_fsm_if bus ();

    router_fsm #(.ADDR_INVALID(2'b11), .STATE_W(3)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    logic [7:0] obs;
    assign obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                  bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};

    string m_st;
    int    m_addr;

    function automatic logic [7:0] exp_out(string s);
        case (s)
            "DA":    return 8'b1000_0000;
            "WTE":   return 8'b0000_0001;
            "LFD":   return 8'b0100_0101;
            "LD":    return 8'b0010_0100;
            "FFS":   return 8'b0000_1001;
            "LAF":   return 8'b0001_0101;
            "LP":    return 8'b0000_0101;
            "CPE":   return 8'b0000_0011;
            default: return 8'bxxxx_xxxx;
        endcase
    endfunction

    function automatic logic empty_of(int a);
        if (a == 0) return bus.fifo_empty_0;
        if (a == 1) return bus.fifo_empty_1;
        if (a == 2) return bus.fifo_empty_2;
        return 1'b0;
    endfunction

    function automatic logic soft_of(int a);
        if (a == 0) return bus.soft_reset_0;
        if (a == 1) return bus.soft_reset_1;
        if (a == 2) return bus.soft_reset_2;
        return 1'b0;
    endfunction

    task automatic model_step();
        string nx;
        nx = m_st;
        case (m_st)
            "DA":  if (bus.pkt_valid && bus.data_in != 2'd3)
                       nx = empty_of(int'(bus.data_in)) ? "LFD" : "WTE";
            "WTE": if (empty_of(m_addr)) nx = "LFD";
            "LFD": nx = "LD";
            "LD":  if (bus.fifo_full) nx = "FFS"; else if (!bus.pkt_valid) nx = "LP";
            "FFS": if (!bus.fifo_full) nx = "LAF";
            "LAF": nx = bus.parity_done ? "DA" : (bus.low_pkt_valid ? "LP" : "LD");
            "LP":  nx = "CPE";
            "CPE": nx = bus.fifo_full ? "FFS" : "DA";
            default: nx = "DA";
        endcase
        if (m_st != "DA" && soft_of(m_addr)) nx = "DA";
        if (m_st == "DA") m_addr = int'(bus.data_in);
        m_st = nx;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        m_st   = "DA";
        m_addr = 0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== exp_out("DA")) begin
            errors++; $display("FAIL reset_state: got %b want %b", obs, exp_out("DA"));
        end
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        tick(); tick();
        checks++;
        if (obs !== exp_out("LD")) begin
            errors++; $display("FAIL reset_reach_ld: got %b want %b", obs, exp_out("LD"));
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (obs !== exp_out("DA") || bus.busy !== 1'b0 || bus.write_enb_reg !== 1'b0) begin
            errors++; $display("FAIL reset_mid_packet: got %b want %b", obs, exp_out("DA"));
        end
        do_reset();
    endtask

    task automatic test_empty_packet();
        string seq [7];
        seq = '{"LFD", "LD", "LD", "LD", "LP", "CPE", "DA"};
        do_reset();
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1; bus.fifo_empty_1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) bus.pkt_valid = 1'b0;
            if (i == 1) bus.data_in = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (obs !== exp_out(seq[i])) begin
                errors++; $display("FAIL empty_packet[%0d] %s: got %b want %b", i, seq[i], obs, exp_out(seq[i]));
            end
        end
    endtask

    task automatic test_busy_fifo();
        do_reset();
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== exp_out("WTE") || bus.write_enb_reg !== 1'b0) begin
                errors++; $display("FAIL busy_fifo_wte[%0d]: got %b want %b", i, obs, exp_out("WTE"));
            end
        end
        bus.fifo_empty_2 = 1'b1;
        tick();
        checks++;
        if (obs !== exp_out("LFD")) begin
            errors++; $display("FAIL busy_fifo_lfd: got %b want %b", obs, exp_out("LFD"));
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        tick(); tick();
        // fifo_full and end-of-packet together: full takes priority
        bus.fifo_full = 1'b1; bus.pkt_valid = 1'b0;
        tick();
        checks++;
        if (obs !== exp_out("FFS") || bus.full_state !== 1'b1 || bus.write_enb_reg !== 1'b0) begin
            errors++; $display("FAIL full_stall_ffs: got %b want %b", obs, exp_out("FFS"));
        end
        tick();
        checks++;
        if (obs !== exp_out("FFS")) begin
            errors++; $display("FAIL full_stall_hold: got %b want %b", obs, exp_out("FFS"));
        end
        bus.fifo_full = 1'b0;
        tick();
        checks++;
        if (obs !== exp_out("LAF")) begin
            errors++; $display("FAIL full_stall_laf: got %b want %b", obs, exp_out("LAF"));
        end
        bus.low_pkt_valid = 1'b1; bus.parity_done = 1'b0;
        tick();
        checks++;
        if (obs !== exp_out("LP")) begin
            errors++; $display("FAIL full_stall_lp: got %b want %b", obs, exp_out("LP"));
        end
    endtask

    task automatic test_invalid_addr();
        do_reset();
        bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_out("DA") || bus.write_enb_reg !== 1'b0) begin
                errors++; $display("FAIL invalid_addr[%0d]: got %b want %b", i, obs, exp_out("DA"));
            end
        end
    endtask

    task automatic test_soft_reset();
        do_reset();
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty_0 = 1'b0;
        tick();
        bus.soft_reset_1 = 1'b1;
        tick();
        checks++;
        if (obs !== exp_out("WTE")) begin
            errors++; $display("FAIL soft_reset_other: got %b want %b", obs, exp_out("WTE"));
        end
        bus.soft_reset_1 = 1'b0; bus.soft_reset_0 = 1'b1;
        tick();
        checks++;
        if (obs !== exp_out("DA")) begin
            errors++; $display("FAIL soft_reset_own: got %b want %b", obs, exp_out("DA"));
        end
        bus.soft_reset_0 = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.pkt_valid     = ($urandom_range(0, 3) != 0);
            bus.data_in       = 2'($urandom_range(0, 3));
            bus.fifo_full     = ($urandom_range(0, 3) == 0);
            bus.fifo_empty_0  = ($urandom_range(0, 2) != 0);
            bus.fifo_empty_1  = ($urandom_range(0, 2) != 0);
            bus.fifo_empty_2  = ($urandom_range(0, 2) != 0);
            bus.soft_reset_0  = ($urandom_range(0, 19) == 0);
            bus.soft_reset_1  = ($urandom_range(0, 19) == 0);
            bus.soft_reset_2  = ($urandom_range(0, 19) == 0);
            bus.parity_done   = ($urandom_range(0, 3) == 0);
            bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (obs !== exp_out(m_st)) begin
                errors++; $display("FAIL random[%0d] %s: got %b want %b", i, m_st, obs, exp_out(m_st));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_empty_packet();
        test_busy_fifo();
        test_full_stall();
        test_invalid_addr();
        test_soft_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
